// File: rtl/ps2_scancode_tracker.sv
// PS/2 set-2 byte decoder: pops receiver bytes, emits make/break events, tracks held key, presses, repeats.
// Latency: event and held/count update at t+1 after capture, repeat_led at t+2; pops at most one byte per 2 cycles.
module ps2_scancode_tracker #(
   parameter int HIST_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   input  logic             kb_overflow,
   output logic             kb_nextdata_n,
   output logic             evt_valid,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_break,
   output logic             held_valid,
   output logic [8:0]       held_code,
   output logic [CNT_W-1:0] press_cnt,
   output logic             repeat_led,
   output logic             ovf_sticky,
   output logic             proto_err
);

   localparam int FILL_W = $clog2(HIST_DEPTH + 1);
   localparam logic [7:0] B_E0 = 8'hE0;
   localparam logic [7:0] B_F0 = 8'hF0;

   typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

   state_t            state_q, state_d;
   logic              capture;
   logic              soft_rst;
   logic              ev_make, ev_break, ev_ext, ev_err;
   logic [8:0]        ev_key;
   logic [8:0]        hist_q [HIST_DEPTH];
   logic [FILL_W-1:0] fill_q;
   logic              hist_same;

   assign capture  = kb_ready & kb_nextdata_n;
   assign soft_rst = rst | clear;
   assign ev_key   = {ev_ext, kb_data};

   always_comb begin
      state_d  = state_q;
      ev_make  = 1'b0;
      ev_break = 1'b0;
      ev_ext   = 1'b0;
      ev_err   = 1'b0;
      if (capture) begin
         case (state_q)
            S_IDLE: begin
               if (kb_data == B_E0)      state_d = S_E0;
               else if (kb_data == B_F0) state_d = S_F0;
               else                      ev_make = 1'b1;
            end
            S_E0: begin
               if (kb_data == B_F0)      state_d = S_E0F0;
               else if (kb_data != B_E0) begin
                  ev_make = 1'b1;
                  ev_ext  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_F0, S_E0F0: begin
               state_d = S_IDLE;
               if (kb_data == B_E0 || kb_data == B_F0) begin
                  ev_err = 1'b1;
               end else begin
                  ev_break = 1'b1;
                  ev_ext   = (state_q == S_E0F0);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      hist_same = 1'b1;
      for (int i = 1; i < HIST_DEPTH; i++) begin
         if (hist_q[i] != hist_q[0]) hist_same = 1'b0;
      end
   end

   // The pop strobe ignores clear: a byte taken during clear must still leave the receiver FIFO.
   always_ff @(posedge clk) begin
      if (rst) kb_nextdata_n <= 1'b1;
      else     kb_nextdata_n <= ~capture;
   end

   always_ff @(posedge clk) begin
      if (soft_rst) begin
         state_q    <= S_IDLE;
         evt_valid  <= 1'b0;
         evt_code   <= 8'h00;
         evt_ext    <= 1'b0;
         evt_break  <= 1'b0;
         held_valid <= 1'b0;
         held_code  <= 9'h000;
         press_cnt  <= '0;
         repeat_led <= 1'b0;
         ovf_sticky <= 1'b0;
         proto_err  <= 1'b0;
         fill_q     <= '0;
         for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= 9'h000;
      end else begin
         state_q    <= state_d;
         evt_valid  <= ev_make | ev_break;
         repeat_led <= (fill_q == FILL_W'(HIST_DEPTH)) && hist_same;
         if (kb_overflow) ovf_sticky <= 1'b1;
         if (ev_err)      proto_err  <= 1'b1;
         if (ev_make | ev_break) begin
            evt_code  <= kb_data;
            evt_ext   <= ev_ext;
            evt_break <= ev_break;
         end
         if (ev_make) begin
            if ((!held_valid || ev_key != held_code) && press_cnt != {CNT_W{1'b1}})
               press_cnt <= press_cnt + CNT_W'(1);
            held_code  <= ev_key;
            held_valid <= 1'b1;
            hist_q[0]  <= ev_key;
            for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
            if (fill_q != FILL_W'(HIST_DEPTH)) fill_q <= fill_q + FILL_W'(1);
         end
         if (ev_break) begin
            fill_q <= '0;
            if (held_valid && ev_key == held_code) held_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_tracker.sv
// Randomized and directed bench for ps2_scancode_tracker; a sequence-level model feeds an event scoreboard.
module tb_ps2_scancode_tracker;

   localparam int HD = 4;
   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, clear, kb_ready, kb_overflow;
   logic [7:0]    kb_data;
   logic          kb_nextdata_n, evt_valid, evt_ext, evt_break, held_valid;
   logic [7:0]    evt_code;
   logic [8:0]    held_code;
   logic [CW-1:0] press_cnt;
   logic          repeat_led, ovf_sticky, proto_err;

   always #5 clk = ~clk;

   ps2_scancode_tracker #(.HIST_DEPTH(HD), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .clear(clear), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .evt_valid(evt_valid),
      .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break), .held_valid(held_valid),
      .held_code(held_code), .press_cnt(press_cnt), .repeat_led(repeat_led),
      .ovf_sticky(ovf_sticky), .proto_err(proto_err)
   );

   typedef struct {
      logic [7:0] code;
      logic       ext, brk, hv, err, rep;
      logic [8:0] hc;
      int         cnt;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0, n_fail = 0;
   int         pops_seen = 0, pops_exp = 0, evts_seen = 0;

   // Reference model: buffered prefix bytes plus list of makes since the last break.
   logic [7:0] pend[$];
   logic [8:0] makes[$];
   logic       m_hv, m_err;
   logic [8:0] m_hc;
   int         m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      pend.delete(); makes.delete();
      m_hv = 1'b0; m_err = 1'b0; m_hc = 9'h000; m_cnt = 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      exp_t e;
      logic [8:0] key;
      logic brk;
      pend.push_back(b);
      if (b == 8'hE0 || b == 8'hF0) begin
         if (pend.size() == 1) return;
         if (pend.size() == 2 && pend[0] == 8'hE0) begin
            if (b == 8'hE0) void'(pend.pop_back());
            return;
         end
         m_err = 1'b1;
         pend.delete();
         return;
      end
      key = {pend[0] == 8'hE0, b};
      brk = (pend.size() >= 2) && (pend[pend.size()-2] == 8'hF0);
      pend.delete();
      if (!brk) begin
         if ((!m_hv || key != m_hc) && m_cnt < CNT_MAX) m_cnt++;
         m_hv = 1'b1; m_hc = key;
         makes.push_back(key);
      end else begin
         if (m_hv && key == m_hc) m_hv = 1'b0;
         makes.delete();
      end
      e.code = b; e.ext = key[8]; e.brk = brk; e.hv = m_hv; e.hc = m_hc;
      e.cnt = m_cnt; e.err = m_err;
      e.rep = (makes.size() >= HD);
      for (int i = 1; i < HD && e.rep; i++)
         if (makes[makes.size()-1-i] != makes[makes.size()-1]) e.rep = 1'b0;
      exp_q.push_back(e);
   endfunction

   // Monitor: pops expected events on evt_valid and checks repeat_led one cycle later.
   logic prev_low = 1'b0, rep_pending = 1'b0, rep_exp = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (kb_nextdata_n === 1'b0) begin
         pops_seen++;
         check("pop_single_cycle", {31'd0, prev_low}, 0);
      end
      if (rep_pending) begin
         check("repeat_led", {31'd0, repeat_led}, {31'd0, rep_exp});
         rep_pending = 1'b0;
      end
      if (evt_valid === 1'b1) begin
         evts_seen++;
         check("evt_with_pop", {31'd0, kb_nextdata_n}, 0);
         if (exp_q.size() == 0) begin
            check("evt_unexpected", {31'd0, evt_valid}, 0);
         end else begin
            e = exp_q.pop_front();
            check("evt_code", {24'd0, evt_code}, {24'd0, e.code});
            check("evt_ext", {31'd0, evt_ext}, {31'd0, e.ext});
            check("evt_break", {31'd0, evt_break}, {31'd0, e.brk});
            check("held_valid", {31'd0, held_valid}, {31'd0, e.hv});
            if (e.hv) check("held_code", {23'd0, held_code}, {23'd0, e.hc});
            check("press_cnt", {28'd0, press_cnt}, e.cnt);
            check("proto_err", {31'd0, proto_err}, {31'd0, e.err});
            rep_exp = e.rep;
            rep_pending = 1'b1;
         end
      end
      prev_low = (kb_nextdata_n === 1'b0);
   end

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      kb_data = b;
      kb_ready = 1'b1;
      while (kb_nextdata_n !== 1'b1 && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 8) check("pop_stall", {31'd0, kb_nextdata_n}, 1);
      model_byte(b);
      pops_exp++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      kb_ready = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      idle(4);
      check({name, "_drain"}, exp_q.size(), 0);
      check({name, "_pops"}, pops_seen, pops_exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, p0, r;
      logic [7:0] b;
      rst = 1'b1; clear = 1'b0; kb_ready = 1'b0; kb_overflow = 1'b0; kb_data = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_nextdata_n", {31'd0, kb_nextdata_n}, 1);
      check("rst_evt_valid", {31'd0, evt_valid}, 0);
      check("rst_evt_code", {24'd0, evt_code}, 0);
      check("rst_evt_ext", {31'd0, evt_ext}, 0);
      check("rst_evt_break", {31'd0, evt_break}, 0);
      check("rst_held_valid", {31'd0, held_valid}, 0);
      check("rst_held_code", {23'd0, held_code}, 0);
      check("rst_press_cnt", {28'd0, press_cnt}, 0);
      check("rst_repeat_led", {31'd0, repeat_led}, 0);
      check("rst_ovf", {31'd0, ovf_sticky}, 0);
      check("rst_proto_err", {31'd0, proto_err}, 0);

      // Make/break with kb_ready held high between bytes.
      e0 = evts_seen; p0 = pops_seen;
      send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
      drain("t1");
      check("t1_events", evts_seen - e0, 2);
      check("t1_pops", pops_seen - p0, 3);
      check("t1_cnt", {28'd0, press_cnt}, 1);

      send_byte(8'hE0); send_byte(8'h75); idle(2);
      check("t2_held_code", {23'd0, held_code}, 9'h175);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      drain("t2");

      repeat (4) send_byte(8'h1C);
      drain("t3");
      check("t3_repeat_on", {31'd0, repeat_led}, 1);
      send_byte(8'hF0); send_byte(8'h1C);
      drain("t3b");
      check("t3_repeat_off", {31'd0, repeat_led}, 0);

      for (int i = 0; i < CNT_MAX + 3; i++) begin
         send_byte(8'h10 + 8'(i)); send_byte(8'hF0); send_byte(8'h10 + 8'(i));
      end
      drain("t4");
      check("t4_saturated", {28'd0, press_cnt}, CNT_MAX);

      do_clear();
      e0 = evts_seen;
      send_byte(8'hF0); send_byte(8'hE0);
      drain("t5");
      check("t5_proto_err", {31'd0, proto_err}, 1);
      check("t5_no_event", evts_seen - e0, 0);
      send_byte(8'h1C);
      drain("t5b");
      check("t5_ext", {31'd0, evt_ext}, 0);

      kb_overflow = 1'b1; @(negedge clk); kb_overflow = 1'b0;
      idle(5);
      check("t6_ovf_set", {31'd0, ovf_sticky}, 1);
      send_byte(8'h2A); send_byte(8'hF0); send_byte(8'h2A);
      drain("t6");
      check("t6_ovf_held", {31'd0, ovf_sticky}, 1);
      do_clear();
      check("t6_ovf_clear", {31'd0, ovf_sticky}, 0);

      send_byte(8'hE0); idle(2);
      rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
      send_byte(8'h1C);
      drain("t6_rst");
      check("t6_rst_ext", {31'd0, evt_ext}, 0);

      send_byte(8'h1D); drain("t6_pre");
      kb_data = 8'h24; kb_ready = 1'b1; clear = 1'b1;
      @(posedge clk); @(negedge clk);
      clear = 1'b0; kb_ready = 1'b0; model_reset(); pops_exp++;
      check("clr_cap_pop", {31'd0, kb_nextdata_n}, 0);
      check("clr_cap_evt", {31'd0, evt_valid}, 0);
      check("clr_cap_held", {31'd0, held_valid}, 0);
      check("clr_cap_cnt", {28'd0, press_cnt}, 0);
      check("clr_cap_code", {24'd0, evt_code}, 0);
      @(negedge clk);
      check("clr_cap_pop_end", {31'd0, kb_nextdata_n}, 1);
      drain("t6_clr");

      // Random traffic with frequent prefixes, repeats and protocol errors.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 15)      b = 8'hE0;
         else if (r < 30) b = 8'hF0;
         else if (r < 75) b = (r < 55) ? 8'h1C : ((r < 65) ? 8'h1D : 8'h75);
         else             b = 8'($urandom_range(1, 127));
         send_byte(b);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
